// File: rtl/booth_op_scheduler.sv
// booth_op_scheduler: streaming front end for a sequential Booth multiplier.
// Queues signed operand pairs with a user tag, runs them one at a time over
// the multiplier's level start/done handshake and presents each product in a
// valid/ready output register. Holding start high while the output slot is
// busy keeps the multiplier parked with a stable product.
// Optional build macro BOOTH_SCHED_STATS_EN adds saturating capture and stall
// counters (stat_ops, stat_stall).
module booth_op_scheduler #(
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TAGW       = 4
) (
  input  logic                   clk,
  input  logic                   rst_overall,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATAWIDTH-1:0]   in_a,
  input  logic [DATAWIDTH-1:0]   in_b,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   mul_start,
  output logic [DATAWIDTH-1:0]   mul_a,
  output logic [DATAWIDTH-1:0]   mul_b,
  input  logic [2*DATAWIDTH-1:0] mul_product,
  input  logic                   mul_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*DATAWIDTH-1:0] out_product,
  output logic [TAGW-1:0]        out_tag
`ifdef BOOTH_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_stall
`endif
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam logic [PTRW:0]   CNT_ZERO = {(PTRW+1){1'b0}};
  localparam logic [PTRW:0]   CNT_ONE  = {{PTRW{1'b0}}, 1'b1};
  localparam logic [PTRW:0]   CNT_FULL = FIFO_DEPTH[PTRW:0];
  localparam logic [PTRW-1:0] PTR_ONE  = {{(PTRW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [DATAWIDTH-1:0] fifo_a_r   [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] fifo_b_r   [FIFO_DEPTH];
  logic [TAGW-1:0]      fifo_tag_r [FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr_r;
  logic [PTRW-1:0]      rd_ptr_r;
  logic [PTRW:0]        count_r;
  logic [PTRW:0]        count_s;
  logic [TAGW-1:0]      tag_r;

  logic push_s;
  logic pop_s;
  logic empty_s;
  logic slot_free_s;
  logic load_s;
  logic capture_s;

  assign empty_s     = (count_r == CNT_ZERO);
  assign slot_free_s = !out_valid || out_ready;

  // Next-state logic: decide when to load the FIFO head and when to capture.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          load_s  = 1'b1;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Product is only taken when the output slot can hold it; otherwise
        // start stays high and the multiplier waits in its finish state.
        if (mul_done && slot_free_s) begin
          capture_s = 1'b1;
          state_s   = ST_RELEASE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_RELEASE: begin
        // Start stays low until done drops so the multiplier returns to idle.
        if (!mul_done) begin
          if (!empty_s) begin
            load_s  = 1'b1;
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_RELEASE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FIFO push/pop decode and next occupancy.
  always_comb begin
    push_s  = in_valid && in_ready;
    pop_s   = capture_s;
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // State register and operand/tag latch toward the multiplier.
  always_ff @(posedge clk) begin
    if (rst_overall) begin
      state_r   <= ST_IDLE;
      mul_start <= 1'b0;
      mul_a     <= {DATAWIDTH{1'b0}};
      mul_b     <= {DATAWIDTH{1'b0}};
      tag_r     <= {TAGW{1'b0}};
    end else begin
      state_r   <= state_s;
      mul_start <= (state_s == ST_ISSUE);
      if (load_s) begin
        mul_a <= fifo_a_r[rd_ptr_r];
        mul_b <= fifo_b_r[rd_ptr_r];
        tag_r <= fifo_tag_r[rd_ptr_r];
      end
    end
  end

  // Operand FIFO storage, pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst_overall) begin
      wr_ptr_r <= {PTRW{1'b0}};
      rd_ptr_r <= {PTRW{1'b0}};
      count_r  <= CNT_ZERO;
      in_ready <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_a_r[i]   <= {DATAWIDTH{1'b0}};
        fifo_b_r[i]   <= {DATAWIDTH{1'b0}};
        fifo_tag_r[i] <= {TAGW{1'b0}};
      end
    end else begin
      count_r  <= count_s;
      in_ready <= (count_s != CNT_FULL);
      if (push_s) begin
        fifo_a_r[wr_ptr_r]   <= in_a;
        fifo_b_r[wr_ptr_r]   <= in_b;
        fifo_tag_r[wr_ptr_r] <= in_tag;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Result register with valid/ready; a capture wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (rst_overall) begin
      out_valid   <= 1'b0;
      out_product <= {(2*DATAWIDTH){1'b0}};
      out_tag     <= {TAGW{1'b0}};
    end else begin
      if (capture_s) begin
        out_valid   <= 1'b1;
        out_product <= mul_product;
        out_tag     <= tag_r;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef BOOTH_SCHED_STATS_EN
  // Saturating counters for completed operations and backpressure stalls.
  always_ff @(posedge clk) begin
    if (rst_overall) begin
      stat_ops   <= 16'h0000;
      stat_stall <= 16'h0000;
    end else begin
      if (capture_s && (stat_ops != 16'hFFFF)) begin
        stat_ops <= stat_ops + 16'h0001;
      end
      if ((state_r == ST_ISSUE) && mul_done && !slot_free_s && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_booth_op_scheduler.sv
// Directed + random bench for booth_op_scheduler. Contains a behavioural
// sequential multiplier (registered done, parks in finish while start is high)
// and a scoreboard queue of expected {tag, product} entries.
module tb_booth_op_scheduler;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int EW    = 2*DW + TW;

  logic clk = 1'b0;
  logic rst_overall;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [TW-1:0] in_tag;
  logic mul_start;
  logic [DW-1:0] mul_a;
  logic [DW-1:0] mul_b;
  logic [2*DW-1:0] mul_product;
  logic mul_done;
  logic out_valid;
  logic out_ready;
  logic [2*DW-1:0] out_product;
  logic [TW-1:0] out_tag;
`ifdef BOOTH_SCHED_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_stall;
  int stall_seen = 0;
`endif

  int checks = 0;
  int failures = 0;
  int res_seen = 0;
  logic [EW-1:0] sb [$];
  int m_state = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  booth_op_scheduler #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH), .TAGW(TW)) dut (
    .clk(clk),
    .rst_overall(rst_overall),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_tag(in_tag),
    .mul_start(mul_start),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_product(mul_product),
    .mul_done(mul_done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_product(out_product),
    .out_tag(out_tag)
`ifdef BOOTH_SCHED_STATS_EN
    ,
    .stat_ops(stat_ops),
    .stat_stall(stat_stall)
`endif
  );

  function automatic logic [2*DW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
  endfunction

  function automatic logic [EW-1:0] ref_entry(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [TW-1:0] tag);
    return {tag, smul(a, b)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural multiplier: DW busy cycles, then finish with a registered done.
  always @(posedge clk) begin
    if (rst_overall) begin
      m_state     <= 0;
      m_cnt       <= 0;
      mul_product <= '0;
      mul_done    <= 1'b0;
    end else begin
      mul_done <= (m_state == 2);
      case (m_state)
        0: if (mul_start) begin
             m_state     <= 1;
             m_cnt       <= DW - 1;
             mul_product <= smul(mul_a, mul_b);
           end
        1: if (m_cnt == 0) m_state <= 2; else m_cnt <= m_cnt - 1;
        2: if (!mul_start) m_state <= 0;
        default: m_state <= 0;
      endcase
    end
  end

  // Scoreboard: push accepted ops, pop and compare on each output handshake.
  always @(negedge clk) begin
    if (rst_overall) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          check("result_product", 32'(out_product), 32'(sb[0][2*DW-1:0]));
          check("result_tag", 32'(out_tag), 32'(sb[0][EW-1:2*DW]));
          void'(sb.pop_front());
          res_seen <= res_seen + 1;
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_entry(in_a, in_b, in_tag));
    end
  end

`ifdef BOOTH_SCHED_STATS_EN
  // Bench-side count of cycles where a finished product is blocked.
  always @(negedge clk) begin
    if (!rst_overall && mul_start && mul_done && out_valid && !out_ready)
      stall_seen <= stall_seen + 1;
  end
`endif

  initial begin
    logic [DW-1:0] ta [5];
    logic [DW-1:0] tbv [5];
    logic [TW-1:0] tt [5];
    int rtime [5];
    logic [EW-1:0] e;
    int n, t, nres, acc_t, acc, r0;
    bit got, a1;
`ifdef BOOTH_SCHED_STATS_EN
    int st0, ss0;
`endif
    ta  = '{8'd12, 8'hFB, 8'd0,  8'd127, 8'hF9};
    tbv = '{8'd12, 8'd6,  8'h80, 8'd1,   8'hF7};
    tt  = '{4'd1,  4'd2,  4'd3,  4'd4,   4'd9};
    rtime = '{0, 0, 0, 0, 0};

    // Reset state
    rst_overall = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    check("rst_out_data", 32'({out_tag, out_product}), 32'd0);
    rst_overall = 1'b0;
    tick();

    // Single op 7 * -3, tag 5: latency 12 from accept edge, one-cycle pulse
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'hFD; in_tag = 4'd5;
    tick();
    in_valid = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick(); n++;
      if (out_valid) got = 1'b1;
    end
    check("single_latency", 32'(n), 32'd12);
    check("single_product", 32'(out_product), 32'h0000FFEB);
    check("single_tag", 32'(out_tag), 32'd5);
    tick();
    check("single_pulse", 32'(out_valid), 32'd0);
    repeat (5) tick();

    // Back-to-back fill, push attempt while full, 14-cycle spacing
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tbv[i]; in_tag = tt[i];
      tick();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_a = ta[4]; in_b = tbv[4]; in_tag = tt[4];
    t = 0; nres = 0; acc_t = -1;
    while (nres < 5 && t < 200) begin
      a1 = in_valid && in_ready;
      tick(); t++;
      if (a1) begin in_valid = 1'b0; acc_t = t; end
      if (out_valid) begin rtime[nres] = t; nres++; end
    end
    check("b2b_results", 32'(nres), 32'd5);
    check("full_accept_time", 32'(acc_t), 32'd10);
    check("b2b_first", 32'(rtime[0]), 32'd9);
    for (int i = 1; i < 5; i++) check("b2b_spacing", 32'(rtime[i] - rtime[i-1]), 32'd14);
    repeat (5) tick();

    // Backpressure: hold out_ready low for 30 cycles with two ops
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'hFC; in_tag = 4'd6;
    tick();
    in_a = 8'h9C; in_b = 8'h9C; in_tag = 4'd7;
    tick();
    in_valid = 1'b0;
    r0 = res_seen;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
`ifdef BOOTH_SCHED_STATS_EN
    st0 = stall_seen; ss0 = int'(stat_stall);
`endif
    for (int i = 0; i < 30; i++) begin
      tick();
      e = sb[0];
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_hold", 32'(out_product), 32'(e[2*DW-1:0]));
    end
    check("stall_start", 32'(mul_start), 32'd1);
    check("stall_done", 32'(mul_done), 32'd1);
    tick();
    out_ready = 1'b1;
    t = 0;
    while (sb.size() != 0 && t < 200) begin tick(); t++; end
    tick();
    check("stall_drain", 32'(res_seen - r0), 32'd2);
`ifdef BOOTH_SCHED_STATS_EN
    check("stat_stall", 32'(int'(stat_stall) - ss0), 32'(stall_seen - st0));
`endif
    repeat (5) tick();

    // Reset during ISSUE with 3 ops queued
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tbv[i]; in_tag = tt[i];
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!mul_start && n < 20) begin tick(); n++; end
    check("pre_rst_issue", 32'(mul_start), 32'd1);
    rst_overall = 1'b1;
    tick();
    rst_overall = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_mul_start", 32'(mul_start), 32'd0);
    check("mid_rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    check("mid_rst_out_data", 32'({out_tag, out_product}), 32'd0);
    r0 = res_seen;
    repeat (60) tick();
    check("mid_rst_no_results", 32'(res_seen - r0), 32'd0);

    // Random operands and random out_ready over 200 accepted ops
    r0 = res_seen; acc = 0; t = 0;
    while (acc < 200 && t < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
      in_tag    = TW'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) acc++;
      tick(); t++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("random_accepted", 32'(acc), 32'd200);
    t = 0;
    while (sb.size() != 0 && t < 2000) begin tick(); t++; end
    tick();
    check("random_results", 32'(res_seen - r0), 32'd200);
`ifdef BOOTH_SCHED_STATS_EN
    check("stat_ops", 32'(stat_ops), 32'd200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
